// File: rtl/change_dispenser.sv
// Change dispenser: accumulates owed change in 5 TK units from the vending controller and
// pays it out one coin at a time over a four-phase req/ack handshake; also counts sales.
module change_dispenser #(
  parameter int PEND_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cash_return,
  input  logic              purchase,
  input  logic              empty10,
  input  logic              coin_ack,
  output logic              coin_req,
  output logic              coin_sel,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  sale_count,
  output logic [1:0]        o_dbg_state,
  output logic [PEND_W-1:0] o_dbg_pending
);

  // Handshake: coin_req rises with coin_sel valid and both hold until coin_ack is seen high;
  // coin_req then drops, and no new coin is requested until coin_ack has been seen low.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  localparam logic [PEND_W+1:0] MAX_PEND = {2'b00, {PEND_W{1'b1}}};

  state_t              r_state;
  state_t              w_next_state;
  logic [PEND_W-1:0]   r_pending;
  logic [PEND_W-1:0]   w_pending_nxt;
  logic                r_coin_req;
  logic                r_coin_sel;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_sale_count;
  logic                w_req_nxt;
  logic                w_sel_nxt;
  logic [1:0]          w_ded;
  logic [PEND_W+1:0]   w_sum;
  logic                w_sat;

  always_comb begin
    w_next_state = r_state;
    w_req_nxt    = r_coin_req;
    w_sel_nxt    = r_coin_sel;
    w_ded        = 2'd0;
    case (r_state)
      S_IDLE: begin
        w_req_nxt = 1'b0;
        if (r_pending != '0) begin
          w_req_nxt    = 1'b1;
          w_next_state = S_REQ;
          // A 10 TK coin needs at least two units owed and a stocked tube.
          if ((r_pending[PEND_W-1:1] != '0) && !empty10) begin
            w_sel_nxt = 1'b1;
            w_ded     = 2'd2;
          end else begin
            w_sel_nxt = 1'b0;
            w_ded     = 2'd1;
          end
        end
      end
      S_REQ: begin
        if (coin_ack) begin
          w_req_nxt    = 1'b0;
          w_next_state = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (!coin_ack) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_req_nxt    = 1'b0;
      end
    endcase
  end

  // ded never exceeds pending, so the sum cannot go negative.
  always_comb begin
    w_sum         = {2'b00, r_pending} + {{PEND_W{1'b0}}, cash_return}
                  - {{PEND_W{1'b0}}, w_ded};
    w_sat         = (w_sum > MAX_PEND);
    w_pending_nxt = w_sat ? {PEND_W{1'b1}} : w_sum[PEND_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_coin_req   <= 1'b0;
      r_coin_sel   <= 1'b0;
      r_overflow   <= 1'b0;
      r_sale_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_pending  <= w_pending_nxt;
      r_coin_req <= w_req_nxt;
      r_coin_sel <= w_sel_nxt;
      if (w_sat) r_overflow <= 1'b1;
      if (purchase) r_sale_count <= r_sale_count + CNT_W'(1);
    end
  end

  assign coin_req      = r_coin_req;
  assign coin_sel      = r_coin_sel;
  assign busy          = (r_pending != '0) || (r_state != S_IDLE);
  assign overflow      = r_overflow;
  assign sale_count    = r_sale_count;
  assign o_dbg_state   = r_state;
  assign o_dbg_pending = r_pending;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin types are queued as expected when change is
// injected and popped when the mechanism model sees each coin request.
module tb_change_dispenser;

  localparam int PEND_W = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        cash_return = 2'b00;
  logic              purchase = 1'b0;
  logic              empty10 = 1'b0;
  logic              coin_ack = 1'b0;
  logic              coin_req;
  logic              coin_sel;
  logic              busy;
  logic              overflow;
  logic [CNT_W-1:0]  sale_count;
  logic [1:0]        dbg_state;
  logic [PEND_W-1:0] dbg_pending;

  int n_checks = 0;
  int n_fail   = 0;
  int paid_tk  = 0;
  logic [0:0] exp_q[$];

  change_dispenser #(.PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cash_return(cash_return), .purchase(purchase),
    .empty10(empty10), .coin_ack(coin_ack), .coin_req(coin_req), .coin_sel(coin_sel),
    .busy(busy), .overflow(overflow), .sale_count(sale_count),
    .o_dbg_state(dbg_state), .o_dbg_pending(dbg_pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"}, {31'd0, coin_req}, 32'd0);
    check({tag, "_sel"}, {31'd0, coin_sel}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check({tag, "_cnt"}, {24'd0, sale_count}, 32'd0);
  endtask

  // Mechanism model: acks k cycles after the request is seen, releases one cycle after
  // the request drops; the coin type is scored against the expected queue.
  task automatic serve_coin(input int k, input int exp_pend);
    int n;
    logic [0:0] exp_sel;
    n = 0;
    while (!coin_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, coin_req}, 32'd1);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 32'd0, 32'd1);
      exp_sel = 1'b0;
    end else begin
      exp_sel = exp_q.pop_front();
    end
    check("coin_sel", {31'd0, coin_sel}, {31'd0, exp_sel});
    check("pend_after_issue", {28'd0, dbg_pending}, exp_pend);
    paid_tk += coin_sel ? 10 : 5;
    for (int i = 0; i < k; i++) begin
      tick();
      check("req_hold", {31'd0, coin_req}, 32'd1);
      check("sel_hold", {31'd0, coin_sel}, {31'd0, exp_sel});
    end
    coin_ack = 1'b1;
    tick();
    check("req_drop", {31'd0, coin_req}, 32'd0);
    tick();
    coin_ack = 1'b0;
    tick();
  endtask

  initial begin
    int pend;
    // 1: reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cash_return = 2'($urandom_range(0, 3));
      purchase    = 1'($urandom_range(0, 1));
      empty10     = 1'($urandom_range(0, 1));
      coin_ack    = 1'($urandom_range(0, 1));
      tick();
      check_idle_outputs("rst_hold");
    end
    cash_return = 2'b00; purchase = 1'b0; empty10 = 1'b0; coin_ack = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check_idle_outputs("rst_release");

    // 2: 15 TK with 10 TK available -> 10 then 5
    cash_return = 2'b11;
    tick();
    cash_return = 2'b00;
    check("t2_pend3", {28'd0, dbg_pending}, 32'd3);
    check("t2_req_latency", {31'd0, coin_req}, 32'd0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    paid_tk = 0;
    serve_coin(2, 1);
    serve_coin(2, 0);
    check("t2_busy_low", {31'd0, busy}, 32'd0);
    check("t2_paid", paid_tk, 32'd15);

    // 3: 10 TK with empty tube -> two 5 TK coins
    empty10 = 1'b1;
    cash_return = 2'b10;
    tick();
    cash_return = 2'b00;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    paid_tk = 0;
    serve_coin(1, 1);
    empty10 = 1'b0;
    serve_coin(1, 0);
    check("t3_paid", paid_tk, 32'd10);
    check("t3_busy_low", {31'd0, busy}, 32'd0);

    // 4: saturation and sticky overflow
    cash_return = 2'b11;
    repeat (6) tick();
    cash_return = 2'b00;
    check("t4_pend_sat", {28'd0, dbg_pending}, 32'd15);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    exp_q.push_back(1'b1);
    pend = 15;
    serve_coin(0, 15);
    while (pend != 0) begin
      if (pend >= 2) begin
        exp_q.push_back(1'b1);
        pend -= 2;
      end else begin
        exp_q.push_back(1'b0);
        pend -= 1;
      end
      serve_coin(0, pend);
    end
    check("t4_drained_busy", {31'd0, busy}, 32'd0);
    check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
    rst = 1'b0;
    #2;
    check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // 5: add and issue on the same edge
    cash_return = 2'b10;
    tick();
    check("t5_pend2", {28'd0, dbg_pending}, 32'd2);
    cash_return = 2'b01;
    tick();
    cash_return = 2'b00;
    exp_q.push_back(1'b1);
    serve_coin(0, 1);
    exp_q.push_back(1'b0);
    serve_coin(0, 0);

    // 6: sale counter wrap, then reset during REQ
    purchase = 1'b1;
    repeat (255) tick();
    check("t6_cnt255", {24'd0, sale_count}, 32'd255);
    repeat (2) tick();
    purchase = 1'b0;
    check("t6_cnt_wrap", {24'd0, sale_count}, 32'd1);
    cash_return = 2'b11;
    tick();
    cash_return = 2'b00;
    tick();
    check("t6_in_req", {31'd0, coin_req}, 32'd1);
    check("t6_pend1", {28'd0, dbg_pending}, 32'd1);
    rst = 1'b0;
    #2;
    check("t6_async_req", {31'd0, coin_req}, 32'd0);
    check("t6_pend_clr", {28'd0, dbg_pending}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_cnt_clr", {24'd0, sale_count}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-side counterpart of the vending controller. Consumes the controller's per-cycle `cash_return` refund code and `purchase` strobe, accumulates owed change in 5 TK units, and pays it out one physical coin at a time over a four-phase req/ack handshake with the coin mechanism. It sits between the vending controller and the coin hopper, and also keeps a running sale count.

## Interface
- `PEND_W`, 4: width of the pending-change counter in 5 TK units. Maximum is 2^PEND_W−1 = 15 units (75 TK).
- `CNT_W`, 8: width of `sale_count`.

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cash_return`  in  2  refund code from the controller: 00=0, 01=5, 10=10, 11=15 TK (the code value is the number of 5 TK units); sampled every edge
- `purchase`  in  1  sale strobe from the controller; sampled every edge
- `empty10`  in  1  10 TK coin tube empty; forces 5 TK coins
- `coin_ack`  in  1  coin mechanism has dropped the requested coin
- `coin_req`  out  1  coin request to the mechanism
- `coin_sel`  out  1  coin type: 0 = 5 TK, 1 = 10 TK; valid while `coin_req`=1
- `busy`  out  1  pending≠0 or FSM≠IDLE
- `overflow`  out  1  sticky; owed change exceeded counter capacity
- `sale_count`  out  CNT_W  number of purchases, modulo 2^CNT_W

## Operation
- Registers: `pending` (PEND_W bits), FSM state, `coin_req`, `coin_sel`, `overflow`, `sale_count`.
- Every edge: `pending` <= `pending` + `add` − `ded`.
  - `add` = `cash_return`.
  - `ded` = units issued on this edge (0, 1 or 2).
  - The sum is computed at PEND_W+2 bits. If the result exceeds the maximum, `pending` saturates to the maximum and `overflow` is set.
  - `overflow` stays set until reset.
- Adding change and issuing a coin on the same edge both take effect.
- FSM states:
  - **IDLE**: `coin_req`=0. If `pending`≠0 (the registered value), issue a coin on this edge and go to REQ:
    - If `pending`≥2 and `empty10`=0: `coin_sel`<=1, `ded`=2.
    - Otherwise: `coin_sel`<=0, `ded`=1.
    - `coin_req`<=1.
  - **REQ**: hold `coin_req`=1 and `coin_sel` stable. When `coin_ack`=1, drive `coin_req`<=0 and go to WAIT_REL.
  - **WAIT_REL**: wait for `coin_ack`=0, then go to IDLE.
- `coin_ack` is ignored in IDLE.
- `empty10` is sampled only at issue time. A change to `empty10` during REQ does not alter `coin_sel`.
- `sale_count` increments on every edge where `purchase`=1 and wraps from 2^CNT_W−1 to 0.
- `busy` is combinational from registers only.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `pending`=0, `coin_req`=0, `coin_sel`=0, `overflow`=0, `sale_count`=0, so `busy`=0.
  - Reset mid-transaction drops `coin_req` immediately and discards owed change.
- Latency: `cash_return`≠0 sampled at edge E with FSM in IDLE and `pending`=0 gives `coin_req`=1 after edge E+1.
- Coin cycle with `coin_ack` rising k cycles after `coin_req`:
  - `coin_req` falls one edge after `coin_ack` is sampled high.
  - The next coin can be issued no earlier than one edge after `coin_ack` is sampled low.
  - Minimum 3 edges per coin at zero mechanism delay.
- `coin_req` and `coin_sel` are glitch-free (registered).

## Test plan
1. Hold `rst`=0 with random inputs -> all outputs 0. Release `rst` -> outputs remain 0 while inputs are 0.
2. `cash_return`=11 for one cycle, `empty10`=0, ack responds 2 cycles after req and releases 1 cycle after req drops:
   - first coin has `coin_sel`=1, `pending` goes 3->1;
   - second coin has `coin_sel`=0, `pending` goes 1->0;
   - `busy` falls after the final ack release.
3. `empty10`=1, `cash_return`=10 for one cycle -> two coins, both `coin_sel`=0, total 10 TK.
4. `coin_ack` held 0 and `cash_return`=11 for 6 consecutive cycles -> `pending` saturates at 15 and `overflow`=1. `overflow` stays 1 after draining until `rst` pulses low.
5. `pending`=2 in IDLE, `empty10`=0, `cash_return`=01 on the issue edge -> 10 TK coin issued and `pending`=1 after the edge.
6. 257 `purchase` pulses -> `sale_count`=1. Then assert `rst`=0 while in REQ -> `coin_req` drops asynchronously and `pending`=0.
